// File: rtl/toy_seq_pkg.sv
// Shared state encodings, opcode values and error codes for the ToyProcessor sequencer.
package toy_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/toy_seq_watchdog.sv
// Fetch watchdog: counts consecutive enabled cycles; expired is high on the LIMIT-th one.
// Combinational expired, one-cycle-registered count; clear has priority over counting.
module toy_seq_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of already-elapsed cycles, so the current one is cnt+1
  assign expired = enable && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/toy_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer owning the PC and fetch handshake.
// Optional fetch timeout is built only when SEQ_TIMEOUT_EN is defined.
module toy_sequencer
  import toy_seq_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int OP_WIDTH    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CLR,
  input  logic                START,
  input  logic                MEM_ACK,
  input  logic [OP_WIDTH-1:0] OPCODE,
  input  logic [PC_WIDTH-1:0] TARGET,
  input  logic                OVERFLOW,
  output logic                MEM_REQ,
  output logic                IR_LOAD,
  output logic                ALU_EN,
  output logic                REG_WE,
  output logic [PC_WIDTH-1:0] PC,
  output logic [2:0]          STATE,
  output logic                HALTED,
  output logic [1:0]          ERR
);

  state_t state;
  logic   tmo;

`ifdef SEQ_TIMEOUT_EN
  toy_seq_watchdog #(
    .LIMIT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk     (CLK),
    .rst     (RESET),
    .clear   (CLR || (state != ST_FETCH)),
    .enable  (state == ST_FETCH),
    .expired (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      PC    <= '0;
      ERR   <= ERR_NONE;
    end else if (CLR) begin
      state <= ST_IDLE;
      PC    <= '0;
      ERR   <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) state <= ST_FETCH;
        end
        ST_FETCH: begin
          // an ack on the limit cycle beats the timeout
          if (MEM_ACK) begin
            PC    <= PC + PC_WIDTH'(1);
            state <= ST_DECODE;
          end else if (tmo) begin
            ERR   <= ERR_TMO;
            state <= ST_HALT;
          end
        end
        ST_DECODE: begin
          if (OPCODE == OP_WIDTH'(OP_NOP)) begin
            state <= ST_FETCH;
          end else if (OPCODE == OP_WIDTH'(OP_HALT)) begin
            state <= ST_HALT;
          end else if (OPCODE == OP_WIDTH'(OP_JMP)) begin
            PC    <= TARGET;
            state <= ST_FETCH;
          end else begin
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          state <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          if (OVERFLOW) begin
            ERR   <= ERR_OVF;
            state <= ST_HALT;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign MEM_REQ = (state == ST_FETCH);
  assign ALU_EN  = (state == ST_EXECUTE);
  assign HALTED  = (state == ST_HALT);
  assign STATE   = state;
  assign IR_LOAD = (state == ST_FETCH) && MEM_ACK;
  assign REG_WE  = (state == ST_WRITEBACK) && !OVERFLOW;

endmodule

// File: tb/tb_toy_sequencer.sv
// Directed plus randomized bench for toy_sequencer against an instruction-level model.
module tb_toy_sequencer;

  logic       CLK = 1'b0;
  logic       RESET, CLR, START, MEM_ACK, OVERFLOW;
  logic [3:0] OPCODE;
  logic [7:0] TARGET;
  logic       MEM_REQ, IR_LOAD, ALU_EN, REG_WE, HALTED;
  logic [7:0] PC;
  logic [2:0] STATE;
  logic [1:0] ERR;

  int checks   = 0;
  int failures = 0;

  // instruction-level model: only PC, error code and halt status are tracked
  int m_pc     = 0;
  int m_err    = 0;
  bit m_halted = 0;

  toy_sequencer #(.PC_WIDTH(8), .OP_WIDTH(4), .MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .RESET(RESET), .CLR(CLR), .START(START), .MEM_ACK(MEM_ACK),
    .OPCODE(OPCODE), .TARGET(TARGET), .OVERFLOW(OVERFLOW),
    .MEM_REQ(MEM_REQ), .IR_LOAD(IR_LOAD), .ALU_EN(ALU_EN), .REG_WE(REG_WE),
    .PC(PC), .STATE(STATE), .HALTED(HALTED), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Don't-care inputs get random values so that stray acks/opcodes must be ignored.
  task automatic noise();
    MEM_ACK  = 1'($urandom_range(0, 1));
    OPCODE   = 4'($urandom_range(0, 15));
    TARGET   = 8'($urandom_range(0, 255));
    OVERFLOW = 1'($urandom_range(0, 1));
  endtask

  // Expected outputs for a cycle spent in phase st (0 idle .. 5 halt).
  task automatic expect_cyc(input int st, input bit irl, input bit rwe);
    chk("state",   STATE,   st);
    chk("mem_req", MEM_REQ, st == 1);
    chk("ir_load", IR_LOAD, irl);
    chk("alu_en",  ALU_EN,  st == 3);
    chk("reg_we",  REG_WE,  rwe);
    chk("halted",  HALTED,  st == 5);
    chk("pc",      PC,      m_pc);
    chk("err",     ERR,     m_err);
  endtask

  task automatic start_seq();
    noise(); START = 1'b1; settle();
    expect_cyc(0, 0, 0);
    tick(); START = 1'b0;
  endtask

  // One instruction from its first FETCH cycle; d = cycles of ack delay.
  task automatic run_instr(input int d, input logic [3:0] op, input logic [7:0] tgt, input bit ov);
    for (int i = 0; i <= d; i++) begin
      noise(); MEM_ACK = (i == d); settle();
      expect_cyc(1, i == d, 0);
      tick();
    end
    m_pc = (m_pc + 1) % 256;
    noise(); OPCODE = op; TARGET = tgt; settle();
    expect_cyc(2, 0, 0);
    tick();
    if (op == 4'hF) begin
      m_halted = 1;
    end else if (op == 4'hE) begin
      m_pc = tgt;
    end else if (op != 4'h0) begin
      noise(); settle();
      expect_cyc(3, 0, 0);
      tick();
      noise(); OVERFLOW = ov; settle();
      expect_cyc(4, 0, !ov);
      tick();
      if (ov) begin
        m_err    = 1;
        m_halted = 1;
      end
    end
  endtask

  task automatic halt_and_clear();
    for (int i = 0; i < 2; i++) begin
      noise(); START = 1'b1; settle();
      expect_cyc(5, 0, 0);
      tick();
    end
    noise(); CLR = 1'b1; START = 1'($urandom_range(0, 1)); settle();
    expect_cyc(5, 0, 0);
    tick();
    CLR = 1'b0; START = 1'b0;
    m_pc = 0; m_err = 0; m_halted = 0;
  endtask

  initial begin
    RESET = 1'b1; CLR = 1'b0; START = 1'b0;
    MEM_ACK = 1'b0; OPCODE = '0; TARGET = '0; OVERFLOW = 1'b0;
    #3;
    expect_cyc(0, 0, 0);
    tick();
    RESET = 1'b0;

    // ALU instruction with immediate ack, then a NOP to confirm the return to FETCH
    start_seq();
    run_instr(0, 4'h3, 8'h00, 0);
    run_instr(0, 4'h0, 8'h00, 0);

    // overflow halts, START is ignored, CLR recovers
    run_instr(1, 4'h3, 8'h00, 1);
    chk("ovf_halted_model", m_halted, 1);
    halt_and_clear();
    start_seq();

    // JMP to 0x40: next fetch shows the target, no ALU strobe on the way
    run_instr(0, 4'hE, 8'h40, 0);
    chk("jmp_pc", PC, 8'h40);

    // PC wrap from 0xFF
    run_instr(0, 4'hE, 8'hFF, 0);
    run_instr(2, 4'h5, 8'h00, 0);

    // CLR during a stalled fetch, then CLR together with START
    run_instr(0, 4'hE, 8'h20, 0);
    noise(); MEM_ACK = 1'b0; CLR = 1'b1; settle();
    expect_cyc(1, 0, 0);
    tick();
    m_pc = 0;
    noise(); START = 1'b1; settle();
    expect_cyc(0, 0, 0);
    tick();
    CLR = 1'b0; START = 1'b0;
    noise(); settle();
    expect_cyc(0, 0, 0);
    start_seq();

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      int         r;
      logic [3:0] op;
      r = $urandom_range(0, 15);
      if (r == 0)      op = 4'h0;
      else if (r == 1) op = 4'hE;
      else if (r == 2) op = 4'hF;
      else             op = 4'($urandom_range(1, 13));
      run_instr($urandom_range(0, 3), op, 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
      if (m_halted) begin
        halt_and_clear();
        start_seq();
      end
    end

`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      noise(); MEM_ACK = 1'b0; settle();
      expect_cyc(1, 0, 0);
      tick();
    end
    m_err = 2;
    halt_and_clear();
    start_seq();
    run_instr(14, 4'h0, 8'h00, 0);
    run_instr(14, 4'h0, 8'h00, 0);
`else
    for (int i = 0; i < 100; i++) begin
      noise(); MEM_ACK = 1'b0; settle();
      expect_cyc(1, 0, 0);
      tick();
    end
`endif

    // asynchronous reset in WRITEBACK suppresses the register write at once
    noise(); MEM_ACK = 1'b1; settle();
    expect_cyc(1, 1, 0);
    tick();
    m_pc = (m_pc + 1) % 256;
    noise(); OPCODE = 4'h3; settle();
    expect_cyc(2, 0, 0);
    tick();
    noise(); settle();
    expect_cyc(3, 0, 0);
    tick();
    noise(); OVERFLOW = 1'b0; settle();
    expect_cyc(4, 0, 1);
    RESET = 1'b1;
    #1;
    m_pc = 0; m_err = 0;
    expect_cyc(0, 0, 0);
    tick();
    RESET = 1'b0;
    noise(); settle();
    expect_cyc(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
